// File: rtl/ecpri_pkg.sv
// ecpri_pkg: shared eCPRI constants, remote-memory header layout and the
// request/response state encoding used by the rx parser and tx builder.
package ecpri_pkg;

  localparam logic [3:0] ECPRI_REV     = 4'd1;
  localparam logic [7:0] MSG_RM_ACCESS = 8'h04;

  localparam logic [3:0] RM_READ     = 4'd0;
  localparam logic [3:0] RM_WRITE    = 4'd1;
  localparam logic [3:0] RM_WRITE_NR = 4'd2;

  localparam logic [3:0] RM_REQ  = 4'd0;
  localparam logic [3:0] RM_RESP = 4'd1;
  localparam logic [3:0] RM_FAIL = 4'd2;

  localparam int CMN_HDR_LEN = 4;
  localparam int RM_HDR_LEN  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR,
    ST_CHK,
    ST_COPY,
    ST_RESP,
    ST_DROP
  } ecpri_state_e;

  typedef struct packed {
    logic [3:0]  revision;
    logic [7:0]  msg_type;
    logic [15:0] payload_size;
    logic [7:0]  acc_id;
    logic [3:0]  rw;
    logic [3:0]  req_resp;
    logic [15:0] ele_id;
    logic [47:0] addr;
    logic [15:0] length;
  } rm_hdr_t;

  // Payload size a well-formed request must announce: only writes carry data.
  function automatic logic [16:0] rm_payload_size(input logic [3:0] rw, input logic [15:0] length);
    return 17'(RM_HDR_LEN) + ((rw != RM_READ) ? {1'b0, length} : 17'd0);
  endfunction

endpackage

// File: rtl/ecpri_byte_copier.sv
// ecpri_byte_copier: streams len bytes from a read-latency-1 source RAM into a
// destination RAM; each write trails its read by one cycle, done pulses after the last write.
module ecpri_byte_copier #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_oe,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_we,
  output logic                  done
);

  logic                  rd_active;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  // The write stage is the read stage delayed by one cycle; done fires once it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_active <= 1'b0;
      rd_cnt    <= '0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      wr_valid  <= 1'b0;
      wr_addr_q <= '0;
      done      <= 1'b0;
    end else begin
      wr_valid  <= rd_active;
      wr_addr_q <= dst_q + rd_cnt;
      done      <= wr_valid && !rd_active;
      if (start && !rd_active && (len != '0)) begin
        rd_active <= 1'b1;
        rd_cnt    <= '0;
        len_q     <= len;
        src_q     <= src_base;
        dst_q     <= dst_base;
      end else if (rd_active) begin
        if (rd_cnt == len_q - 1'b1) begin
          rd_active <= 1'b0;
        end
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  assign rd_oe   = rd_active;
  assign rd_addr = rd_active ? (src_q + rd_cnt) : '0;
  assign wr_we   = wr_valid;
  assign wr_addr = wr_valid ? wr_addr_q : '0;
  assign wr_data = wr_valid ? rd_data : '0;

endmodule

// File: rtl/ecpri_rm_req_parser.sv
// ecpri_rm_req_parser: validates an eCPRI remote-memory request held in rx RAM,
// copies write payload to the payload RAM and issues a response command.
// Build macro ECPRI_RM_STATS_EN adds saturating accept/drop/busy counters.
module ecpri_rm_req_parser
  import ecpri_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LEN    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_avail,
  input  logic [15:0]           pkt_len,
  output logic [ADDR_WIDTH-1:0] rx_addr,
  output logic                  rx_oe,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [ADDR_WIDTH-1:0] pl_addr,
  output logic [DATA_WIDTH-1:0] pl_data,
  output logic                  pl_we,
  output logic                  send_read_resp,
  output logic                  send_write_resp,
  output logic [7:0]            resp_payload_len,
  output logic [7:0]            rm_acc_id,
  output logic [15:0]           rm_ele_id,
  output logic [47:0]           rm_addr,
  output logic [15:0]           rm_len,
  input  logic                  resp_ack,
  output logic                  busy
`ifdef ECPRI_RM_STATS_EN
  ,
  output logic [15:0]           stat_rx_ok,
  output logic [15:0]           stat_rx_drop,
  output logic [15:0]           stat_rx_busy
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PAYLOAD_BASE = ADDR_WIDTH'(CMN_HDR_LEN + RM_HDR_LEN);

  ecpri_state_e          state;
  ecpri_state_e          next_state;
  logic [4:0]            hdr_cnt;
  logic [4:0]            hdr_idx;
  logic                  hdr_rd;
  logic [7:0]            rx_byte;
  rm_hdr_t               hdr_q;
  logic [15:0]           pkt_len_q;
  logic                  hdr_ok;
  logic                  copy_start;
  logic                  copy_done;
  logic [ADDR_WIDTH-1:0] cp_rd_addr;
  logic                  cp_rd_oe;

  assign rx_byte = rx_data[7:0];
  assign hdr_idx = hdr_cnt - 5'd1;
  assign hdr_rd  = (state == ST_HDR) && !hdr_cnt[4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // hdr_cnt drives addresses 0..15; the byte read at count k-1 arrives at count k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_cnt <= '0;
    end else if (state == ST_HDR) begin
      hdr_cnt <= hdr_cnt + 5'd1;
    end else begin
      hdr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q     <= '0;
      pkt_len_q <= '0;
    end else begin
      if (state == ST_IDLE && pkt_avail) begin
        pkt_len_q <= pkt_len;
      end
      if (state == ST_HDR && hdr_cnt != 5'd0) begin
        case (hdr_idx)
          5'd0:  hdr_q.revision <= rx_byte[7:4];
          5'd1:  hdr_q.msg_type <= rx_byte;
          5'd2, 5'd3: hdr_q.payload_size <= {hdr_q.payload_size[7:0], rx_byte};
          5'd4:  hdr_q.acc_id <= rx_byte;
          5'd5: begin
            hdr_q.rw       <= rx_byte[7:4];
            hdr_q.req_resp <= rx_byte[3:0];
          end
          5'd6, 5'd7: hdr_q.ele_id <= {hdr_q.ele_id[7:0], rx_byte};
          5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13: hdr_q.addr <= {hdr_q.addr[39:0], rx_byte};
          5'd14, 5'd15: hdr_q.length <= {hdr_q.length[7:0], rx_byte};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hdr_ok = (hdr_q.revision == ECPRI_REV)
          && (hdr_q.msg_type == MSG_RM_ACCESS)
          && (hdr_q.req_resp == RM_REQ)
          && ((hdr_q.rw == RM_READ) || (hdr_q.rw == RM_WRITE) || (hdr_q.rw == RM_WRITE_NR))
          && (hdr_q.length <= 16'(MAX_LEN))
          && ({1'b0, hdr_q.payload_size} == rm_payload_size(hdr_q.rw, hdr_q.length))
          && ({1'b0, pkt_len_q} >= 17'(CMN_HDR_LEN) + {1'b0, hdr_q.payload_size});
  end

  always_comb begin
    next_state = state;
    copy_start = 1'b0;
    case (state)
      ST_IDLE: if (pkt_avail) next_state = ST_HDR;
      ST_HDR:  if (hdr_cnt == 5'd16) next_state = ST_CHK;
      ST_CHK: begin
        if (!hdr_ok) begin
          next_state = ST_DROP;
        end else if (hdr_q.rw == RM_READ) begin
          next_state = ST_RESP;
        end else if (hdr_q.length == 16'd0) begin
          next_state = (hdr_q.rw == RM_WRITE) ? ST_RESP : ST_IDLE;
        end else begin
          next_state = ST_COPY;
          copy_start = 1'b1;
        end
      end
      ST_COPY: if (copy_done) next_state = (hdr_q.rw == RM_WRITE) ? ST_RESP : ST_IDLE;
      ST_RESP: if (resp_ack) next_state = ST_IDLE;
      ST_DROP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  ecpri_byte_copier #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_copier (
    .clk      (clk),
    .reset    (reset),
    .start    (copy_start),
    .src_base (PAYLOAD_BASE),
    .dst_base ('0),
    .len      (ADDR_WIDTH'(hdr_q.length)),
    .rd_addr  (cp_rd_addr),
    .rd_oe    (cp_rd_oe),
    .rd_data  (rx_data),
    .wr_addr  (pl_addr),
    .wr_data  (pl_data),
    .wr_we    (pl_we),
    .done     (copy_done)
  );

  assign rx_oe   = hdr_rd | cp_rd_oe;
  assign rx_addr = hdr_rd ? ADDR_WIDTH'(hdr_cnt) : cp_rd_addr;

  assign busy             = (state != ST_IDLE);
  assign send_read_resp   = (state == ST_RESP) && (hdr_q.rw == RM_READ);
  assign send_write_resp  = (state == ST_RESP) && (hdr_q.rw == RM_WRITE);
  assign resp_payload_len = send_read_resp ? hdr_q.length[7:0] : 8'd0;
  assign rm_acc_id        = hdr_q.acc_id;
  assign rm_ele_id        = hdr_q.ele_id;
  assign rm_addr          = hdr_q.addr;
  assign rm_len           = hdr_q.length;

`ifdef ECPRI_RM_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rx_ok   <= '0;
      stat_rx_drop <= '0;
      stat_rx_busy <= '0;
    end else begin
      if (state == ST_CHK && hdr_ok && stat_rx_ok != 16'hFFFF) begin
        stat_rx_ok <= stat_rx_ok + 16'd1;
      end
      if (state == ST_DROP && stat_rx_drop != 16'hFFFF) begin
        stat_rx_drop <= stat_rx_drop + 16'd1;
      end
      if (pkt_avail && state != ST_IDLE && stat_rx_busy != 16'hFFFF) begin
        stat_rx_busy <= stat_rx_busy + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ecpri_rm_req_parser.sv
// tb_ecpri_rm_req_parser: directed and randomized requests against a cycle-table
// reference model of the parser; build with ECPRI_RM_STATS_EN to also check the counters.
module tb_ecpri_rm_req_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_avail = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic [15:0] rx_addr;
  logic        rx_oe;
  logic [7:0]  rx_data = 8'd0;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic        pl_we;
  logic        send_read_resp, send_write_resp;
  logic [7:0]  resp_payload_len, rm_acc_id;
  logic [15:0] rm_ele_id, rm_len;
  logic [47:0] rm_addr;
  logic        resp_ack = 1'b0;
  logic        busy;
`ifdef ECPRI_RM_STATS_EN
  logic [15:0] stat_rx_ok, stat_rx_drop, stat_rx_busy;
`endif

  ecpri_rm_req_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_LEN(255)) dut (
    .clk(clk), .reset(reset), .pkt_avail(pkt_avail), .pkt_len(pkt_len),
    .rx_addr(rx_addr), .rx_oe(rx_oe), .rx_data(rx_data),
    .pl_addr(pl_addr), .pl_data(pl_data), .pl_we(pl_we),
    .send_read_resp(send_read_resp), .send_write_resp(send_write_resp),
    .resp_payload_len(resp_payload_len), .rm_acc_id(rm_acc_id), .rm_ele_id(rm_ele_id),
    .rm_addr(rm_addr), .rm_len(rm_len), .resp_ack(resp_ack), .busy(busy)
`ifdef ECPRI_RM_STATS_EN
    , .stat_rx_ok(stat_rx_ok), .stat_rx_drop(stat_rx_drop), .stat_rx_busy(stat_rx_busy)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] rx_mem [0:511];
  always @(posedge clk) if (rx_oe) rx_data <= rx_mem[rx_addr[8:0]];

  wire [140:0] all_out = {rx_addr, rx_oe, pl_addr, pl_data, pl_we, send_read_resp, send_write_resp,
                          resp_payload_len, rm_acc_id, rm_ele_id, rm_addr, rm_len, busy};

  int checks = 0;
  int errors = 0;

  // Packet under test and expected counters
  int p_rev, p_msg, p_psize, p_acc, p_rw, p_rr, p_ele, p_len;
  logic [47:0] p_addr;
  int exp_ok = 0, exp_drop = 0, exp_busy = 0;

  // Model expectations
  bit e_accept;
  int e_cmd_cycle, e_kind, e_busy_fall, e_reads, e_pl_cnt;
  logic [7:0] e_resp_len;

  // Observations
  int obs_cmd_cycle, obs_kind, obs_busy_fall, obs_reads;
  bit obs_unstable, obs_timeout;
  logic [7:0] obs_resp_len, obs_acc;
  logic [15:0] obs_ele, obs_len;
  logic [47:0] obs_addr;
  int pl_cyc_q[$];
  int pl_addr_q[$];
  logic [7:0] pl_data_q[$];

  task automatic build_pkt(input int rev, input int msg, input int psize, input int acc, input int rw,
                           input int rr, input int ele, input logic [47:0] addr, input int len);
    p_rev = rev; p_msg = msg; p_psize = psize; p_acc = acc; p_rw = rw; p_rr = rr;
    p_ele = ele; p_addr = addr; p_len = len;
    rx_mem[0] = {rev[3:0], 4'h0};
    rx_mem[1] = msg[7:0];
    rx_mem[2] = psize[15:8];
    rx_mem[3] = psize[7:0];
    rx_mem[4] = acc[7:0];
    rx_mem[5] = {rw[3:0], rr[3:0]};
    rx_mem[6] = ele[15:8];
    rx_mem[7] = ele[7:0];
    for (int i = 0; i < 6; i++) rx_mem[8 + i] = addr[47 - 8*i -: 8];
    rx_mem[14] = len[15:8];
    rx_mem[15] = len[7:0];
    for (int i = 16; i < 512; i++) rx_mem[i] = 8'($urandom);
  endtask

  // Expected behaviour straight from the request rules and the cycle table.
  task automatic model(input int plen, input int d);
    int n;
    e_accept = (p_rev == 1) && (p_msg == 8'h04) && (p_rr == 0) && (p_rw <= 2) && (p_len <= 255)
            && (p_psize == 12 + ((p_rw != 0) ? p_len : 0)) && (plen >= 4 + p_psize);
    n = (e_accept && p_rw != 0) ? p_len : 0;
    e_reads = 16 + n; e_pl_cnt = n; e_cmd_cycle = -1; e_kind = 0; e_resp_len = 8'd0;
    if (!e_accept) begin
      e_busy_fall = 20; exp_drop++;
    end else begin
      exp_ok++;
      if (p_rw == 2) begin
        e_busy_fall = (n == 0) ? 19 : 21 + n;
      end else begin
        e_kind      = (p_rw == 0) ? 1 : 2;
        e_cmd_cycle = (p_rw == 0 || n == 0) ? 19 : 21 + n;
        e_resp_len  = (p_rw == 0) ? 8'(p_len) : 8'd0;
        e_busy_fall = e_cmd_cycle + d + 1;
      end
    end
  endtask

  // Launches one packet at cycle 0 and records what the DUT does, cycle by cycle.
  task automatic applyStimulus(input int plen, input int ack_delay, input int inject_cycle);
    int cyc;
    obs_cmd_cycle = -1; obs_kind = 0; obs_busy_fall = -1; obs_reads = 0;
    obs_unstable = 0; obs_timeout = 0;
    pl_cyc_q.delete(); pl_addr_q.delete(); pl_data_q.delete();
    @(negedge clk);
    pkt_len = 16'(plen);
    pkt_avail = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      pkt_avail = (cyc == inject_cycle);
      resp_ack = 1'b0;
      if (rx_oe) obs_reads++;
      if (pl_we) begin
        pl_cyc_q.push_back(cyc); pl_addr_q.push_back(int'(pl_addr)); pl_data_q.push_back(pl_data);
      end
      if (send_read_resp || send_write_resp) begin
        if (obs_cmd_cycle < 0) begin
          obs_cmd_cycle = cyc;
          obs_kind = (send_read_resp ? 1 : 0) + (send_write_resp ? 2 : 0);
          obs_resp_len = resp_payload_len; obs_acc = rm_acc_id; obs_ele = rm_ele_id;
          obs_addr = rm_addr; obs_len = rm_len;
        end else if ({resp_payload_len, rm_acc_id, rm_ele_id, rm_addr, rm_len} !==
                     {obs_resp_len, obs_acc, obs_ele, obs_addr, obs_len}) begin
          obs_unstable = 1;
        end
        if (cyc >= obs_cmd_cycle + ack_delay) resp_ack = 1'b1;
      end
      if (!busy) begin
        obs_busy_fall = cyc;
        break;
      end
      if (cyc >= 400) begin
        obs_timeout = 1;
        break;
      end
    end
    pkt_avail = 1'b0;
    resp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", all_out); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (all_out !== '0) begin errors++; $display("[TB] FAIL idle_outputs: got %h expected 0", all_out); end
`ifdef ECPRI_RM_STATS_EN
    checks++; if ({stat_rx_ok, stat_rx_drop, stat_rx_busy} !== 48'd0) begin errors++;
      $display("[TB] FAIL reset_stats: got %h expected 0", {stat_rx_ok, stat_rx_drop, stat_rx_busy}); end
`endif
  endtask

  task automatic test_read();
    build_pkt(1, 8'h04, 12, 8'h5A, 0, 0, 16'h1234, 48'h0000_AABB_CCDD, 8);
    model(16, 3);
    applyStimulus(16, 3, -1);
    checks++; if (obs_cmd_cycle !== 19) begin errors++; $display("[TB] FAIL read_cmd_cycle: got %0d expected 19", obs_cmd_cycle); end
    checks++; if (obs_kind !== 1) begin errors++; $display("[TB] FAIL read_cmd_kind: got %0d expected 1", obs_kind); end
    checks++; if (obs_resp_len !== 8'd8) begin errors++; $display("[TB] FAIL read_resp_len: got %0d expected 8", obs_resp_len); end
    checks++; if ({obs_acc, obs_ele, obs_addr, obs_len} !== {8'h5A, 16'h1234, 48'h0000_AABB_CCDD, 16'd8}) begin errors++;
      $display("[TB] FAIL read_fields: got %h expected %h", {obs_acc, obs_ele, obs_addr, obs_len}, {8'h5A, 16'h1234, 48'h0000_AABB_CCDD, 16'd8}); end
    checks++; if (pl_cyc_q.size() !== 0) begin errors++; $display("[TB] FAIL read_no_pl_we: got %0d writes expected 0", pl_cyc_q.size()); end
    checks++; if (obs_busy_fall !== 23) begin errors++; $display("[TB] FAIL read_busy_fall: got %0d expected 23", obs_busy_fall); end
  endtask

  task automatic test_write();
    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_pkt(1, 8'h04, 16, 8'h33, 1, 0, 16'h0102, 48'h10, 4);
    for (int i = 0; i < 4; i++) rx_mem[16 + i] = exp_b[i];
    model(20, 0);
    applyStimulus(20, 0, -1);
    checks++; if (pl_cyc_q.size() !== 4) begin errors++; $display("[TB] FAIL write_pl_count: got %0d expected 4", pl_cyc_q.size()); end
    for (int i = 0; i < 4 && i < pl_cyc_q.size(); i++) begin
      checks++;
      if (pl_cyc_q[i] !== 20 + i || pl_addr_q[i] !== i || pl_data_q[i] !== exp_b[i]) begin errors++;
        $display("[TB] FAIL write_pl_%0d: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h",
                 i, pl_cyc_q[i], pl_addr_q[i], pl_data_q[i], 20 + i, i, exp_b[i]); end
    end
    checks++; if (obs_cmd_cycle !== 25 || obs_kind !== 2) begin errors++;
      $display("[TB] FAIL write_cmd: got cyc %0d kind %0d expected cyc 25 kind 2", obs_cmd_cycle, obs_kind); end
    checks++; if (obs_resp_len !== 8'd0) begin errors++; $display("[TB] FAIL write_resp_len: got %0d expected 0", obs_resp_len); end
  endtask

  task automatic test_drop();
    int plen;
    for (int v = 0; v < 6; v++) begin
      plen = 16;
      case (v)
        0: build_pkt(1, 8'h02, 12, 1, 0, 0, 5, 48'h1, 8);
        1: build_pkt(2, 8'h04, 12, 1, 0, 0, 5, 48'h1, 8);
        2: begin build_pkt(1, 8'h04, 15, 1, 1, 0, 5, 48'h1, 4); plen = 19; end
        3: begin build_pkt(1, 8'h04, 312, 1, 1, 0, 5, 48'h1, 300); plen = 316; end
        4: build_pkt(1, 8'h04, 12, 1, 0, 1, 5, 48'h1, 8);
        default: plen = 15;
      endcase
      model(plen, 0);
      applyStimulus(plen, 0, -1);
      checks++; if (obs_cmd_cycle !== -1 || pl_cyc_q.size() !== 0 || obs_busy_fall !== 20) begin errors++;
        $display("[TB] FAIL drop_%0d: got cmd %0d pl %0d busy_fall %0d expected cmd -1 pl 0 busy_fall 20",
                 v, obs_cmd_cycle, pl_cyc_q.size(), obs_busy_fall); end
`ifdef ECPRI_RM_STATS_EN
      checks++; if (stat_rx_drop !== 16'(exp_drop)) begin errors++;
        $display("[TB] FAIL drop_stat_%0d: got %0d expected %0d", v, stat_rx_drop, exp_drop); end
`endif
    end
  endtask

  task automatic test_random();
    int len, rw, rev, msg, rr, psize, plen, d;
    logic [47:0] a;
    for (int k = 0; k < 30; k++) begin
      rw = $urandom_range(0, 2);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 300) : $urandom_range(0, 12);
      rev = 1; msg = 8'h04; rr = 0;
      psize = 12 + ((rw != 0) ? len : 0);
      plen = 4 + psize + $urandom_range(0, 2);
      case ($urandom_range(0, 11))
        0: rev = $urandom_range(2, 15);
        1: msg = $urandom_range(5, 255);
        2: rr = $urandom_range(1, 15);
        3: rw = $urandom_range(3, 15);
        4: psize = psize + 1;
        5: plen = 3 + psize;
        default: ;
      endcase
      d = $urandom_range(0, 3);
      a = {16'($urandom), 32'($urandom)};
      build_pkt(rev, msg, psize, $urandom_range(0, 255), rw, rr, $urandom_range(0, 65535), a, len);
      model(plen, d);
      applyStimulus(plen, d, -1);
      checks++; if (obs_timeout) begin errors++; $display("[TB] FAIL rnd%0d_timeout: got no return to idle expected busy_fall %0d", k, e_busy_fall); end
      checks++; if (obs_cmd_cycle !== e_cmd_cycle || obs_kind !== e_kind) begin errors++;
        $display("[TB] FAIL rnd%0d_cmd: got cyc %0d kind %0d expected cyc %0d kind %0d", k, obs_cmd_cycle, obs_kind, e_cmd_cycle, e_kind); end
      checks++; if (obs_busy_fall !== e_busy_fall) begin errors++;
        $display("[TB] FAIL rnd%0d_busy_fall: got %0d expected %0d", k, obs_busy_fall, e_busy_fall); end
      checks++; if (obs_reads !== e_reads || pl_cyc_q.size() !== e_pl_cnt) begin errors++;
        $display("[TB] FAIL rnd%0d_counts: got reads %0d writes %0d expected reads %0d writes %0d", k, obs_reads, pl_cyc_q.size(), e_reads, e_pl_cnt); end
      if (e_kind != 0 && obs_cmd_cycle >= 0) begin
        checks++; if ({obs_resp_len, obs_acc, obs_ele, obs_addr, obs_len} !== {e_resp_len, 8'(p_acc), 16'(p_ele), p_addr, 16'(p_len)} || obs_unstable) begin errors++;
          $display("[TB] FAIL rnd%0d_fields: got %h unstable %0d expected %h", k, {obs_resp_len, obs_acc, obs_ele, obs_addr, obs_len},
                   obs_unstable, {e_resp_len, 8'(p_acc), 16'(p_ele), p_addr, 16'(p_len)}); end
      end
      for (int i = 0; i < pl_cyc_q.size() && i < e_pl_cnt; i++) begin
        checks++;
        if (pl_cyc_q[i] !== 20 + i || pl_addr_q[i] !== i || pl_data_q[i] !== rx_mem[16 + i]) begin errors++;
          $display("[TB] FAIL rnd%0d_pl%0d: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h",
                   k, i, pl_cyc_q[i], pl_addr_q[i], pl_data_q[i], 20 + i, i, rx_mem[16 + i]); end
      end
    end
`ifdef ECPRI_RM_STATS_EN
    checks++; if ({stat_rx_ok, stat_rx_drop} !== {16'(exp_ok), 16'(exp_drop)}) begin errors++;
      $display("[TB] FAIL rnd_stats: got ok %0d drop %0d expected ok %0d drop %0d", stat_rx_ok, stat_rx_drop, exp_ok, exp_drop); end
`endif
  endtask

  task automatic test_busy_ignore();
    build_pkt(1, 8'h04, 22, 8'h77, 1, 0, 16'hBEEF, 48'h42, 10);
    model(26, 1);
    exp_busy++;
    applyStimulus(26, 1, 22);
    checks++; if (obs_cmd_cycle !== 31 || obs_busy_fall !== 33 || pl_cyc_q.size() !== 10) begin errors++;
      $display("[TB] FAIL busy_ignore_first: got cmd %0d busy_fall %0d writes %0d expected cmd 31 busy_fall 33 writes 10",
               obs_cmd_cycle, obs_busy_fall, pl_cyc_q.size()); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_idle: got busy %b expected 0", busy); end
`ifdef ECPRI_RM_STATS_EN
    checks++; if (stat_rx_busy !== 16'(exp_busy)) begin errors++;
      $display("[TB] FAIL busy_stat: got %0d expected %0d", stat_rx_busy, exp_busy); end
`endif
  endtask

  task automatic test_reset_mid_copy();
    build_pkt(1, 8'h04, 42, 8'h11, 1, 0, 16'h2222, 48'h1, 30);
    @(negedge clk);
    pkt_len = 16'd46; pkt_avail = 1'b1;
    @(negedge clk);
    pkt_avail = 1'b0;
    repeat (23) @(negedge clk);
    checks++; if (pl_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_copy_active: got pl_we %b expected 1", pl_we); end
    reset = 1'b1;
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("[TB] FAIL mid_copy_reset: got %h expected 0", all_out); end
    @(negedge clk);
    checks++; if (all_out !== '0) begin errors++; $display("[TB] FAIL mid_copy_reset_hold: got %h expected 0", all_out); end
    reset = 1'b0;
    exp_ok = 0; exp_drop = 0; exp_busy = 0;
    build_pkt(1, 8'h04, 12, 8'h9C, 0, 0, 16'h0F0F, 48'hCAFE, 16);
    model(16, 0);
    applyStimulus(16, 0, -1);
    checks++; if (obs_cmd_cycle !== 19 || obs_kind !== 1 || obs_busy_fall !== 20 || obs_resp_len !== 8'd16) begin errors++;
      $display("[TB] FAIL post_reset_read: got cmd %0d kind %0d busy_fall %0d len %0d expected cmd 19 kind 1 busy_fall 20 len 16",
               obs_cmd_cycle, obs_kind, obs_busy_fall, obs_resp_len); end
`ifdef ECPRI_RM_STATS_EN
    checks++; if ({stat_rx_ok, stat_rx_drop, stat_rx_busy} !== {16'(exp_ok), 16'(exp_drop), 16'(exp_busy)}) begin errors++;
      $display("[TB] FAIL post_reset_stats: got %h expected %h", {stat_rx_ok, stat_rx_drop, stat_rx_busy}, {16'(exp_ok), 16'(exp_drop), 16'(exp_busy)}); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rx_mem[i] = 8'd0;
    test_reset();
    test_read();
    test_write();
    test_drop();
    test_busy_ignore();
    test_random();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecpri_rm_req_parser.md
# ecpri_rm_req_parser

Parses a received eCPRI Remote Memory Access request held in the receive packet RAM. Validates the common header and the remote-memory header, and copies write-request payload into the payload RAM. Then issues a response command with the extracted header fields to the downstream eCPRI response builder. Sits between the Ethernet/UDP receive stripper and the eCPRI transmit/response stage.

## Interface
- DATA_WIDTH, 8, RAM data width (bytes only).
- ADDR_WIDTH, 16, RAM address width.
- MAX_LEN, 255, largest accepted remote-memory length in bytes (≤255, since the response length is 8 bits).
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- pkt_avail  in  1  one-cycle pulse: rx RAM holds a complete eCPRI packet starting at address 0.
- pkt_len  in  16  byte count of that packet; sampled together with pkt_avail.
- rx_addr  out  ADDR_WIDTH  rx RAM read address.
- rx_oe  out  1  rx RAM read enable.
- rx_data  in  8  rx RAM read data; valid the cycle after rx_addr/rx_oe.
- pl_addr, pl_data, pl_we  out  ADDR_WIDTH/8/1  payload RAM write port.
- send_read_resp, send_write_resp  out  1  response command level; held until resp_ack.
- resp_payload_len  out  8  payload byte count of the response.
- rm_acc_id  out  8  remote access id; valid while a response command is high.
- rm_ele_id  out  16  element id; same validity.
- rm_addr  out  48  remote address; same validity.
- rm_len  out  16  requested length; same validity.
- resp_ack  in  1  downstream accepted the command.
- busy  out  1  high from pkt_avail acceptance until the return to IDLE.

## Operation
- All outputs reset to 0; the state register resets to IDLE.
- States: IDLE → HDR → CHK → (COPY) → RESP → IDLE; CHK → DROP → IDLE.
- IDLE: pkt_avail=1 latches pkt_len, sets busy, goes to HDR. pkt_avail while busy is ignored.
- HDR: reads addresses 0..15 back to back (rx_oe=1) and captures each byte one cycle later:
  - b0[7:4] revision.
  - b1 message type.
  - b2..3 payload size, big-endian.
  - b4 acc_id.
  - b5[7:4] rw code.
  - b5[3:0] req/resp code.
  - b6..7 ele_id.
  - b8..13 address, big-endian.
  - b14..15 length.
- CHK (one cycle). Accept only if all of the following hold:
  - revision==1.
  - msg type==0x04.
  - req/resp==0 (request).
  - rw ∈ {0 read, 1 write, 2 write-no-resp}.
  - length ≤ MAX_LEN.
  - payload size == 12 + (rw≠0 ? length : 0).
  - pkt_len ≥ 4 + payload size.
- Any failed check → DROP (one cycle, no RAM writes, no command), then IDLE.
- Read request → RESP with send_read_resp=1 and resp_payload_len=length[7:0].
- Write with length 0 → RESP (write) or IDLE (write-no-resp) directly.
- Write / write-no-resp with length >0 → COPY:
  - reads rx addresses 16..16+length−1.
  - writes pl_addr 0..length−1 with pl_we=1, one cycle behind each read.
- After COPY: write → RESP with send_write_resp=1 and resp_payload_len=0; write-no-resp → IDLE.
- RESP: holds the command and rm_* fields stable until resp_ack=1. That cycle it clears the command, and the next cycle it is in IDLE with busy=0.
- rx_oe and pl_we are 0 outside HDR and COPY.
- Addresses are counters from 0. No wrap-around can occur because length ≤ 255.

## Timing
- Cycle 0 = pkt_avail sampled high in IDLE.
- Cycles 1..16 drive rx_addr 0..15. The last header byte is captured at the end of cycle 17; CHK occupies cycle 18.
- Read: send_read_resp rises at cycle 19.
- Write with N bytes: reads on cycles 19..18+N, pl writes on cycles 20..19+N, send_write_resp rises at cycle 21+N.
- Dropped packet: busy falls at cycle 20.
- resp_ack is accepted only in RESP, and may arrive the same cycle the command rises. The minimum command width is 1 cycle.
- reset mid-operation immediately clears all outputs and any partial copy. The payload RAM contents are then undefined.

## Configuration
- ECPRI_RM_STATS_EN defined: adds three 16-bit saturating counters, reset to 0 and readable as outputs:
  - stat_rx_ok: increments in CHK on accept.
  - stat_rx_drop: increments in DROP.
  - stat_rx_busy: increments on pkt_avail while busy.
- ECPRI_RM_STATS_EN undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Structure
- Shared package ecpri_pkg holds:
  - ECPRI_REV=1, MSG_RM_ACCESS=8'h04.
  - rw codes RM_READ/RM_WRITE/RM_WRITE_NR.
  - req/resp codes RM_REQ/RM_RESP/RM_FAIL.
  - header offsets CMN_HDR_LEN=4, RM_HDR_LEN=12.
  - the state encoding (also used by the tx builder).
- Sub-module ecpri_byte_copier handles the RAM-to-RAM copy: source/destination base, length, start/done, and the one-cycle read-to-write pipeline.

## Test plan
- Read request (acc_id 0x5A, ele_id 0x1234, addr 0x0000_AABB_CCDD, len 8, payload size 12) → send_read_resp at cycle 19, resp_payload_len=8, fields match; no pl_we; resp_ack at cycle 22 clears the command and busy falls at cycle 23.
- Write request len 4, payload DE AD BE EF → pl_addr 0..3 written on cycles 20..23, send_write_resp at cycle 25, resp_payload_len=0.
- Msg type 0x02 or revision 2 → no command, no pl_we, busy falls at cycle 20, stat_rx_drop=1 (stats build).
- Write with payload size 12+3 but len 4 → dropped; write len 300 with MAX_LEN=255 → dropped.
- pkt_avail pulsed during COPY → ignored, first packet completes normally, stat_rx_busy=1.
- reset asserted mid-COPY → next cycle all outputs 0, state IDLE; a fresh read request then completes with the normal latency.
